// File: rtl/mu_arbiter.sv
// rtl/mu_arbiter.sv - two-requester round-robin arbiter for the MemoryUnit start/busy port
// Buffers one request per requester and serialises them onto the single MemoryUnit port.
module mu_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r0_we,
  input  logic              r0_start,
  output logic              r0_busy,
  output logic [DATA_W-1:0] r0_q,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_data,
  input  logic              r1_we,
  input  logic              r1_start,
  output logic              r1_busy,
  output logic [DATA_W-1:0] r1_q,
  output logic [ADDR_W-1:0] mu_address,
  output logic [DATA_W-1:0] mu_data,
  output logic              mu_we,
  output logic              mu_start,
  input  logic              mu_busy,
  input  logic [DATA_W-1:0] mu_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             pend_q, pend_d;
  logic [1:0]             busy_q, busy_d;
  logic [1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [1:0][DATA_W-1:0] data_q, data_d;
  logic [1:0]             we_q, we_d;
  logic [1:0][DATA_W-1:0] rq_q, rq_d;
  logic                   grant_q, grant_d;
  logic                   prio_q, prio_d;
  logic [ADDR_W-1:0]      mu_address_q, mu_address_d;
  logic [DATA_W-1:0]      mu_data_q, mu_data_d;
  logic                   mu_we_q, mu_we_d;
  logic                   mu_start_q, mu_start_d;

  logic [1:0]             req_start;
  logic [1:0]             req_we;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_data;
  logic                   win;
  logic                   in_srv_d;

  assign req_start = {r1_start, r0_start};
  assign req_we    = {r1_we, r0_we};
  assign req_addr  = {r1_address, r0_address};
  assign req_data  = {r1_data, r0_data};

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    rq_d         = rq_q;
    grant_d      = grant_q;
    prio_d       = prio_q;
    mu_address_d = mu_address_q;
    mu_data_d    = mu_data_q;
    mu_we_d      = mu_we_q;
    mu_start_d   = mu_start_q;
    win          = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          win          = (&pend_q) ? prio_q : pend_q[1];
          grant_d      = win;
          mu_address_d = addr_q[win];
          mu_data_d    = data_q[win];
          mu_we_d      = we_q[win];
          pend_d[win]  = 1'b0;
          mu_start_d   = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (mu_busy) begin
          mu_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!mu_busy) begin
          if (!mu_we_q) begin
            rq_d[grant_q] = mu_q;
          end
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start is only accepted while the requester is fully idle; busy_q covers pend and service.
    for (int n = 0; n < 2; n++) begin
      if (req_start[n] && !busy_q[n]) begin
        pend_d[n] = 1'b1;
        addr_d[n] = req_addr[n];
        data_d[n] = req_data[n];
        we_d[n]   = req_we[n];
      end
    end

    in_srv_d = (state_d != IDLE);
    busy_d   = pend_d | ({grant_d, ~grant_d} & {2{in_srv_d}});
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      busy_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= '0;
      rq_q         <= '0;
      grant_q      <= 1'b0;
      prio_q       <= 1'b0;
      mu_address_q <= '0;
      mu_data_q    <= '0;
      mu_we_q      <= 1'b0;
      mu_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      rq_q         <= rq_d;
      grant_q      <= grant_d;
      prio_q       <= prio_d;
      mu_address_q <= mu_address_d;
      mu_data_q    <= mu_data_d;
      mu_we_q      <= mu_we_d;
      mu_start_q   <= mu_start_d;
    end
  end

  assign r0_busy    = busy_q[0];
  assign r1_busy    = busy_q[1];
  assign r0_q       = rq_q[0];
  assign r1_q       = rq_q[1];
  assign mu_address = mu_address_q;
  assign mu_data    = mu_data_q;
  assign mu_we      = mu_we_q;
  assign mu_start   = mu_start_q;

endmodule

// File: doc/mu_arbiter.md
# mu_arbiter

Two-requester arbiter that shares the single MemoryUnit start/busy port between the CPU (requester 0) and a second bus master such as a DMA or blitter (requester 1). Each requester issues a one-cycle start pulse. The block buffers the request and serialises the requests onto the MemoryUnit with round-robin fairness. It then returns read data and a per-requester busy. It sits between the CPU/DMA and MemoryUnit in the FPGC4 top level, in the clk domain.

## Interface
- ADDR_W, 27, address width (MemoryUnit address space)
- DATA_W, 32, data/q width
- clk  in  1  system clock (50 MHz)
- nreset  in  1  reset; asynchronous, active-low
- r0_address / r1_address  in  ADDR_W  requester address, sampled on start
- r0_data / r1_data  in  DATA_W  write data, sampled on start
- r0_we / r1_we  in  1  write enable, sampled on start
- r0_start / r1_start  in  1  one-cycle request pulse
- r0_busy / r1_busy  out  1  request pending or in service
- r0_q / r1_q  out  DATA_W  read result, held until that requester's next completion
- mu_address  out  ADDR_W  to MemoryUnit
- mu_data  out  DATA_W  to MemoryUnit
- mu_we  out  1  to MemoryUnit
- mu_start  out  1  to MemoryUnit
- mu_busy  in  1  from MemoryUnit
- mu_q  in  DATA_W  from MemoryUnit, valid when mu_busy falls

## Operation
- Clocking and reset are fixed: one clock, clk; reset is asynchronous and active-low, nreset.
- Per-requester request buffer: pend flag, address, data and we registers.
  - rN_start high at an edge while pendN=0 and requester N is not in service: load the buffer and set pendN.
  - rN_start while rN_busy=1 is a protocol violation. It is ignored: the buffer is unchanged and no second request is queued.
- rN_busy = pendN OR (in service and granted to N). All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE, any pend set: choose the winner and set grant.
    - Only one pend set: that requester wins.
    - Both set: the requester indicated by prio wins.
    - Copy the winner's buffer to mu_address/mu_data/mu_we, clear its pend, set mu_start=1, go to ISSUE.
  - ISSUE: hold mu_start=1 until mu_busy=1 is sampled. On that edge, mu_start=0 and go to WAIT_DONE.
  - WAIT_DONE: on the edge where mu_busy=0 is sampled:
    - load r{grant}_q from mu_q, except when mu_we=1 (q is unchanged on writes);
    - clear in-service, so r{grant}_busy falls on the same edge q updates;
    - set prio to the non-granted requester and go to IDLE.
- prio toggles only on completion, which gives strict alternation when both requesters are continuously loaded.
- mu_address/mu_data/mu_we are held stable from grant until the next grant.

## Timing
- Reset values: r0_busy=r1_busy=0, r0_q=r1_q=0, mu_start=0, mu_we=0, mu_address=0, mu_data=0, state=IDLE, prio=0, both pend=0, grant=0.
- Start sampled at edge E0:
  - rN_busy=1 after E0;
  - if idle, mu_start=1 after E1;
  - if mu_busy rises by E2, mu_start drops after E2.
- Completion edge Ec (mu_busy sampled 0): q and busy=0 visible after Ec, state=IDLE.
- A pending request from the other requester is issued at Ec+1, giving one idle cycle on mu_start between back-to-back transactions.
- Simultaneous starts at the same edge: both pend set and both busy high. The prio winner is issued first; the other is issued one cycle after the first completes.
- A start arriving on the completion edge of the other requester is buffered. It is then served in turn under round-robin.
- The same requester's start on its own completion edge is ignored, because busy was still 1 when it was sampled.
- Reset asserted mid-transaction: all state returns to reset values asynchronously and mu_start drops immediately. The MemoryUnit is reset by the same reset.
- mu_busy already high while in IDLE is ignored.

## Test plan
- Reset: hold nreset=0 with random inputs. Required: all outputs 0. Release nreset, then pulse r0_start (addr 0x0000100, we=0) with mu_q=0xDEADBEEF returned after 5 cycles of busy. Required: mu_start high after E1, mu_address=0x0000100, r0_q=0xDEADBEEF when r0_busy falls.
- Simultaneous starts, prio=0: r0 addr 0x10 and r1 addr 0x20 in the same cycle. Required: mu_address 0x10 then 0x20, both busy high from E0, r1_busy falls exactly one completion after r0_busy.
- Fairness: both requesters re-pulse start immediately after each of their own completions, for 8 transactions. Required: grants strictly alternate 0,1,0,1,…
- Write: r1_we=1, data 0x12345678, addr 0x7FFFFFF. Required: mu_we=1, mu_data=0x12345678, mu_address=0x7FFFFFF; r1_q keeps its previous value.
- Violation and edge start:
  - r0_start pulsed again while r0_busy=1. Required: exactly one MemoryUnit transaction occurs.
  - r1_start pulsed on r0's completion edge. Required: r1 is issued at Ec+1.
- Mid-operation reset: assert nreset=0 while in WAIT_DONE. Required: mu_start, busy and q all drop to 0 without a clock edge, and the next request after release behaves normally.
